// File: rtl/keypad_scanner.sv
// 3x3 matrix keypad scanner: row rotation, column synchronisation, full-frame
// classification and debounced single-key acceptance with a press strobe.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1200,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       hwclk,
    input  logic       reset,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       press_pulse
);

    localparam int CNT_W   = $clog2(SETTLE_CYCLES);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0] RES_NONE  = 4'd0;
    localparam logic [3:0] RES_MULTI = 4'hF;

    typedef enum logic [1:0] {ROW0, ROW1, ROW2} row_t;

    row_t               state;
    row_t               state_next;
    logic [CNT_W-1:0]   slot_cnt;
    logic               slot_end;
    logic [2:0]         rows;
    logic [2:0]         rows_next;
    logic [2:0]         col_meta;
    logic [2:0]         col_sync;
    logic [2:0]         col_hit;
    logic [8:0]         hit;
    logic [8:0]         frame_hits;
    logic               frame_edge;
    logic [3:0]         result;
    logic [3:0]         cand;
    logic [MATCH_W-1:0] match;
    logic               accept_p1;

    // 0 = no key, 1..9 = single key (bit index + 1), 15 = two or more keys.
    function automatic logic [3:0] classify(input logic [8:0] v);
        logic [3:0] code;
        int         n;
        code = RES_NONE;
        n    = 0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) begin
                n    = n + 1;
                code = 4'(i + 1);
            end
        end
        if (n >= 2) code = RES_MULTI;
        return code;
    endfunction

    function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] c);
        if (c >= MATCH_W'(DEBOUNCE_SCANS)) return c;
        return c + MATCH_W'(1);
    endfunction

    assign slot_end   = (slot_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign frame_edge = slot_end && (state == ROW2);
    assign col_hit    = ~col_sync;
    assign frame_hits = {col_hit, hit[5:0]};
    assign result     = classify(frame_hits);

    assign keypad_r1 = rows[0];
    assign keypad_r2 = rows[1];
    assign keypad_r3 = rows[2];

    // Row scan: state register and slot counter
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state    <= ROW0;
            slot_cnt <= '0;
            rows     <= 3'b110;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_end ? '0 : slot_cnt + CNT_W'(1);
            rows     <= rows_next;
        end
    end

    always_comb begin
        state_next = state;
        rows_next  = 3'b111;
        if (slot_end) begin
            case (state)
                ROW0:    state_next = ROW1;
                ROW1:    state_next = ROW2;
                default: state_next = ROW0;
            endcase
        end
        case (state_next)
            ROW0:    rows_next = 3'b110;
            ROW1:    rows_next = 3'b101;
            default: rows_next = 3'b011;
        endcase
    end

    // Column synchroniser and per-row hit capture
    always_ff @(posedge hwclk) begin
        if (reset) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
            hit      <= '0;
        end else begin
            col_meta <= {keypad_c3, keypad_c2, keypad_c1};
            col_sync <= col_meta;
            if (slot_end) begin
                case (state)
                    ROW0:    hit[2:0] <= col_hit;
                    ROW1:    hit[5:3] <= col_hit;
                    default: hit      <= '0;
                endcase
            end
        end
    end

    // Frame debounce; accept_p1 marks the frame where the count first saturates
    always_ff @(posedge hwclk) begin
        if (reset) begin
            cand      <= RES_NONE;
            match     <= '0;
            accept_p1 <= 1'b0;
        end else begin
            accept_p1 <= 1'b0;
            if (frame_edge) begin
                if (result == cand) begin
                    match     <= sat_inc(match);
                    accept_p1 <= (match == MATCH_W'(DEBOUNCE_SCANS - 1));
                end else begin
                    cand      <= result;
                    match     <= MATCH_W'(1);
                    accept_p1 <= (DEBOUNCE_SCANS == 1);
                end
            end
        end
    end

    // Acceptance stage; a key only registers from the released state
    always_ff @(posedge hwclk) begin
        if (reset) begin
            button      <= 4'd0;
            bstate      <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (accept_p1) begin
                if (cand == RES_NONE) begin
                    bstate <= 1'b0;
                end else if (cand != RES_MULTI && !bstate) begin
                    button      <= cand;
                    bstate      <= 1'b1;
                    press_pulse <= 1'b1;
                end
            end
        end
    end

endmodule
